// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), each held no_of_samples clocks.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (tx_done moves to the end of STOP2).
module uart_tx #(
  parameter int unsigned data_size     = 8,
  parameter int unsigned parity_on     = 1,
  parameter int unsigned even_parity   = 1,
  parameter int unsigned no_of_samples = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [data_size-1:0] tx_data,
  output logic                 Tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [3:0] LAST_SAMPLE = 4'(no_of_samples - 1);
  localparam logic [2:0] LAST_BIT    = 3'(data_size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_TWO_STOP_EN
    , S_STOP2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [data_size-1:0] shift_q, shift_d;
  logic [3:0]           sample_q, sample_d;
  logic [2:0]           bit_q, bit_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    bit_end  = (sample_q == LAST_SAMPLE);

    if (state_q != S_IDLE) begin
      sample_d = bit_end ? '0 : sample_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = (even_parity != 0) ? ^tx_data : ~^tx_data;
          sample_d = '0;
          bit_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (parity_on != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          state_d = S_STOP2;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_EN
      S_STOP2: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Tx is registered, so it is derived from the state being entered rather than the current one.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      sample_q <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share one stimulus; each is checked every cycle
// against a frame-level model that expands each accepted word into its expected line samples.
module tb_uart_tx;

  typedef bit bitq_t[$];

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  localparam int NI = 4;
  // per-instance configuration: data bits, parity on, even parity, samples per bit
  localparam int DS [NI] = '{8, 8, 8, 5};
  localparam int PO [NI] = '{1, 1, 0, 0};
  localparam int EV [NI] = '{1, 0, 1, 0};
  localparam int NS [NI] = '{8, 8, 8, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_w [NI];
  logic       busy_w [NI];
  logic       done_w [NI];

  int errors = 0;
  int checks = 0;

  bitq_t mq [NI];
  logic  et [NI];
  logic  eb [NI];
  logic  ed [NI];

  always #5 clk = ~clk;

  uart_tx #(.data_size(8), .parity_on(1), .even_parity(1), .no_of_samples(8)) u0 (
    .sys_clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.data_size(8), .parity_on(1), .even_parity(0), .no_of_samples(8)) u1 (
    .sys_clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.data_size(8), .parity_on(0), .even_parity(1), .no_of_samples(8)) u2 (
    .sys_clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.data_size(5), .parity_on(0), .even_parity(0), .no_of_samples(3)) u3 (
    .sys_clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data[4:0]),
    .Tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  function automatic bitq_t frame(input logic [7:0] d, input int ds, input int po,
                                  input int ev, input int ns);
    bitq_t q;
    bit    bits[$];
    int    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < ds; k++) begin
      bits.push_back(d[k]);
      ones += int'(d[k]);
    end
    if (po != 0) bits.push_back(ev != 0 ? (ones % 2 == 1) : (ones % 2 == 0));
    for (int s = 0; s < STOPS; s++) bits.push_back(1'b1);
    foreach (bits[b]) for (int r = 0; r < ns; r++) q.push_back(bits[b]);
    return q;
  endfunction

  task automatic chk(input string tag, input int idx, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t got=%0d exp=%0d", tag, idx, $time, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mq[i].delete();
        et[i] = 1'b1; eb[i] = 1'b0; ed[i] = 1'b0;
      end else if (mq[i].size() != 0) begin
        void'(mq[i].pop_front());
        if (mq[i].size() == 0) begin
          et[i] = 1'b1; eb[i] = 1'b0; ed[i] = 1'b1;
        end else begin
          et[i] = mq[i][0]; eb[i] = 1'b1; ed[i] = 1'b0;
        end
      end else if (tx_start) begin
        mq[i] = frame(tx_data, DS[i], PO[i], EV[i], NS[i]);
        et[i] = mq[i][0]; eb[i] = 1'b1; ed[i] = 1'b0;
      end else begin
        et[i] = 1'b1; eb[i] = 1'b0; ed[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("Tx", i, int'(tx_w[i]), int'(et[i]));
      chk("tx_busy", i, int'(busy_w[i]), int'(eb[i]));
      chk("tx_done", i, int'(done_w[i]), int'(ed[i]));
    end
  endtask

  initial begin
    int bc;
    int dc;
    bit found;

    // reset held with tx_start high: reset must win
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) step();
    rst = 1'b0;
    tx_start = 1'b0;
    repeat (3) step();

    // single 0xA5 frame: busy length and one done pulse on the default instance
    bc = 0; dc = 0;
    tx_start = 1'b1; tx_data = 8'hA5;
    repeat (110) begin
      step();
      tx_start = 1'b0;
      bc += int'(busy_w[0]);
      dc += int'(done_w[0]);
    end
    chk("busy_cycles_A5", 0, bc, (1 + 8 + 1 + STOPS) * 8);
    chk("done_count_A5", 0, dc, 1);

    // 0x01 exercises even/odd parity and the parity-less frame
    bc = 0;
    tx_start = 1'b1; tx_data = 8'h01;
    repeat (110) begin
      step();
      tx_start = 1'b0;
      bc += int'(busy_w[2]);
    end
    chk("busy_cycles_noparity", 2, bc, (1 + 8 + STOPS) * 8);

    // tx_start with new data while busy is ignored
    dc = 0;
    tx_start = 1'b1; tx_data = 8'hA5;
    step();
    tx_start = 1'b0;
    repeat (20) begin step(); dc += int'(done_w[0]); end
    tx_start = 1'b1; tx_data = 8'h3C;
    repeat (3) begin step(); dc += int'(done_w[0]); end
    tx_start = 1'b0; tx_data = 8'h00;
    repeat (90) begin step(); dc += int'(done_w[0]); end
    chk("done_count_ignored", 0, dc, 1);

    // back-to-back: start accepted in the tx_done cycle
    tx_start = 1'b1; tx_data = 8'hA5;
    step();
    tx_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (done_w[0]) found = 1'b1;
    end
    chk("done_seen", 0, int'(found), 1);
    tx_start = 1'b1; tx_data = 8'hFF;
    step();
    tx_start = 1'b0;
    chk("b2b_start_low", 0, int'(tx_w[0]), 0);
    repeat (100) step();

    // tx_start held high with data changing every cycle
    dc = 0;
    tx_start = 1'b1;
    repeat (300) begin
      tx_data = 8'($urandom);
      step();
      dc += int'(done_w[0]);
    end
    tx_start = 1'b0;
    repeat (100) begin step(); dc += int'(done_w[0]); end
    chk("done_count_held", 0, dc, 300 / ((1 + 8 + 1 + STOPS) * 8 + 1) +
        ((300 % ((1 + 8 + 1 + STOPS) * 8 + 1)) != 0 ? 1 : 0));

    // random words with random start timing
    for (int f = 0; f < 40; f++) begin
      tx_data  = 8'($urandom);
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      repeat ($urandom_range(20, 110)) step();
    end
    repeat (110) step();

    // reset mid-frame aborts with no later tx_done
    tx_start = 1'b1; tx_data = 8'h5A;
    step();
    tx_start = 1'b0;
    repeat (30) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    dc = 0;
    repeat (120) begin step(); dc += int'(done_w[0]); end
    chk("done_after_abort", 0, dc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
